// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset sequencer releasing NumStages resets spaced StageCycles apart
// Ports:
//   clk        - system clock
//   ext_rst_n  - board reset, asynchronous, active-low (assertion async, release synchronised)
//   lock_i     - PLL locked flag, asynchronous, synchronised internally
//   sw_rst_req - single-cycle software reset request, clk domain, honoured only once all stages are out
//   rst        - active-high stage resets, rst[0] released first
//   rst_done   - high once every stage is released
//   busy       - high while releasing (or re-asserting) stages
// Optional feature macro: RESET_SEQUENCER_ORDERED_ASSERT_EN
//   undefined - sw_rst_req re-asserts every stage at once and resequences
//   defined   - sw_rst_req re-asserts stages top-down, StageCycles apart, then resequences
module reset_sequencer #(
    parameter int NumStages   = 4,
    parameter int StageCycles = 16,
    parameter int SyncStages  = 2
) (
    input  logic                 clk,
    input  logic                 ext_rst_n,
    input  logic                 lock_i,
    input  logic                 sw_rst_req,
    output logic [NumStages-1:0] rst,
    output logic                 rst_done,
    output logic                 busy
);
    localparam int CntW   = $clog2(StageCycles + 1);
    localparam int StageW = (NumStages > 1) ? $clog2(NumStages) : 1;
    localparam logic [CntW-1:0]      CntLast   = CntW'(StageCycles - 1);
    localparam logic [StageW-1:0]    StageLast = StageW'(NumStages - 1);
    localparam logic [NumStages-1:0] OneHot0   = NumStages'(1);

    generate
        if (NumStages < 1) begin : g_bad_num_stages
            $error("reset_sequencer: NumStages must be >= 1");
        end
        if (StageCycles < 1) begin : g_bad_stage_cycles
            $error("reset_sequencer: StageCycles must be >= 1");
        end
        if (SyncStages < 2) begin : g_bad_sync_stages
            $error("reset_sequencer: SyncStages must be >= 2");
        end
    endgenerate

`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
    typedef enum logic [1:0] {S_WAIT, S_RELEASE, S_DONE, S_ASSERT} state_t;
`else
    typedef enum logic [1:0] {S_WAIT, S_RELEASE, S_DONE} state_t;
`endif

    // Power-up values match the reset values so an FPGA starts in reset.
    logic [SyncStages-1:0] ext_chain  = '0;
    logic [SyncStages-1:0] lock_chain = '0;
    state_t                state      = S_WAIT;
    logic [CntW-1:0]       cnt        = '0;
    logic [StageW-1:0]     stage      = '0;
    logic [NumStages-1:0]  rst_q      = '1;
    logic                  done_q     = 1'b0;
    logic                  busy_q     = 1'b0;

    state_t                state_d;
    logic [CntW-1:0]       cnt_d;
    logic [StageW-1:0]     stage_d;
    logic [NumStages-1:0]  rst_d;
    logic                  done_d;
    logic                  busy_d;

    logic ext_sync;
    logic lock_sync;

    assign ext_sync  = ext_chain[SyncStages-1];
    assign lock_sync = lock_chain[SyncStages-1];

    // The ext chain shifts in a constant 1: assertion is async, release is synchronised.
    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            ext_chain  <= '0;
            lock_chain <= '0;
        end else begin
            ext_chain  <= {ext_chain[SyncStages-2:0], 1'b1};
            lock_chain <= {lock_chain[SyncStages-2:0], lock_i};
        end
    end

    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state  <= S_WAIT;
            cnt    <= '0;
            stage  <= '0;
            rst_q  <= '1;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            stage  <= stage_d;
            rst_q  <= rst_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        stage_d = stage;
        rst_d   = rst_q;
        done_d  = done_q;
        busy_d  = busy_q;

        // Losing lock outranks everything, including a pending software request.
        if (state != S_WAIT && !lock_sync) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            stage_d = '0;
            rst_d   = '1;
            done_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state)
                S_RELEASE: begin
                    if (cnt == CntLast) begin
                        cnt_d = '0;
                        rst_d = rst_q & ~(OneHot0 << stage);
                        if (stage == StageLast) begin
                            state_d = S_DONE;
                            stage_d = '0;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            stage_d = stage + StageW'(1);
                        end
                    end else begin
                        cnt_d = cnt + CntW'(1);
                    end
                end
                S_DONE: begin
                    if (sw_rst_req) begin
                        done_d = 1'b0;
                        cnt_d  = '0;
`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
                        // Top stage goes back into reset first; a single-stage build is done at once.
                        rst_d = rst_q | (OneHot0 << StageLast);
                        if (NumStages == 1) begin
                            state_d = S_WAIT;
                            stage_d = '0;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_ASSERT;
                            stage_d = StageLast;
                            busy_d  = 1'b1;
                        end
`else
                        state_d = S_WAIT;
                        stage_d = '0;
                        rst_d   = '1;
                        busy_d  = 1'b0;
`endif
                    end
                end
`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
                S_ASSERT: begin
                    // stage holds the lowest index already re-asserted.
                    if (cnt == CntLast) begin
                        cnt_d   = '0;
                        stage_d = stage - StageW'(1);
                        rst_d   = rst_q | (OneHot0 << (stage - StageW'(1)));
                        if (stage == StageW'(1)) begin
                            state_d = S_WAIT;
                            stage_d = '0;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt + CntW'(1);
                    end
                end
`endif
                default: begin
                    cnt_d   = '0;
                    stage_d = '0;
                    rst_d   = '1;
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    if (ext_sync && lock_sync) begin
                        state_d = S_RELEASE;
                        busy_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    assign rst      = rst_q;
    assign rst_done = done_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer (default and 1-stage/1-cycle builds)
module tb_reset_sequencer;
    localparam int SS = 2;
    localparam int SC = 16;
    localparam int NS = 4;

    logic       clk = 1'b0;
    logic       ext_rst_n;
    logic       lock_i;
    logic       sw_rst_req;
    logic       sw1;
    logic [3:0] rst;
    logic       rst_done;
    logic       busy;
    logic [0:0] rst1;
    logic       done1;
    logic       busy1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.NumStages(NS), .StageCycles(SC), .SyncStages(SS)) dut (
        .clk(clk), .ext_rst_n(ext_rst_n), .lock_i(lock_i), .sw_rst_req(sw_rst_req),
        .rst(rst), .rst_done(rst_done), .busy(busy)
    );

    reset_sequencer #(.NumStages(1), .StageCycles(1), .SyncStages(SS)) dut1 (
        .clk(clk), .ext_rst_n(ext_rst_n), .lock_i(lock_i), .sw_rst_req(sw1),
        .rst(rst1), .rst_done(done1), .busy(busy1)
    );

    // Edge e counts posedges since the start event (ext release or lock rise, lock already high).
    // Stage j is released at edge SS+1+(j+1)*SC.
    function automatic int released(int e, int ns, int sc);
        int k = 0;
        for (int j = 0; j < ns; j++)
            if (e >= SS + 1 + (j + 1) * sc) k++;
        return k;
    endfunction

    function automatic logic [3:0] exp_rst(int e);
        logic [3:0] all_set = 4'hF;
        return all_set << released(e, NS, SC);
    endfunction

    function automatic logic exp_done(int e);
        return released(e, NS, SC) == NS;
    endfunction

    function automatic logic exp_busy(int e);
        return (e >= SS + 1) && (released(e, NS, SC) < NS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input int e);
        chk({tag, "_rst"}, 32'(rst), 32'(exp_rst(e)));
        chk({tag, "_done"}, 32'(rst_done), 32'(exp_done(e)));
        chk({tag, "_busy"}, 32'(busy), 32'(exp_busy(e)));
    endtask

    initial begin
        int stop_e;
        int p;
        int hold;
        logic [3:0] all_set;
        all_set = 4'hF;
        ext_rst_n = 1'b0;
        lock_i = 1'b1;
        sw_rst_req = 1'b0;
        sw1 = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset_rst", 32'(rst), 32'hF);
        chk("reset_done", 32'(rst_done), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_rst1", 32'(rst1), 32'h1);

        // Power-on release with lock high; random sw_rst_req pulses while releasing are ignored
        ext_rst_n = 1'b1;
        for (int e = 1; e <= 75; e++) begin
            tick();
            chk_main("release", e);
            chk("release_rst1", 32'(rst1), 32'(e < SS + 2));
            chk("release_done1", 32'(done1), 32'(e >= SS + 2));
            chk("release_busy1", 32'(busy1), 32'(e == SS + 1));
            sw_rst_req = (e + 1 >= SS + 2 && e + 1 <= 66) ? ($urandom_range(0, 3) == 0) : 1'b0;
            sw1 = (e + 1 == SS + 2);
        end
        sw_rst_req = 1'b0;
        sw1 = 1'b0;

        // Software reset from DONE
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
        for (int j = 0; j < 48; j++) begin
            chk("ordered_rst", 32'(rst), 32'(all_set << (NS - 1 - j / SC)));
            chk("ordered_busy", 32'(busy), 32'h1);
            chk("ordered_done", 32'(rst_done), 32'h0);
            tick();
        end
        for (int j = 48; j <= 48 + 66; j++) begin
            chk_main("ordered_reseq", j - 46);
            if (j < 48 + 66) tick();
        end
`else
        for (int j = 0; j <= 66; j++) begin
            chk_main("swrst_reseq", j + 2);
            if (j < 66) tick();
        end
`endif

        // Lock loss while DONE
        lock_i = 1'b0;
        for (int e = 1; e <= SS + 1; e++) begin
            tick();
            chk("lockloss_rst", 32'(rst), (e <= SS) ? 32'h0 : 32'hF);
            chk("lockloss_done", 32'(rst_done), (e <= SS) ? 32'h1 : 32'h0);
        end
        hold = $urandom_range(5, 40);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("lockloss_hold", 32'(rst), 32'hF);
            chk("lockloss_busy", 32'(busy), 32'h0);
        end
        lock_i = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            tick();
            chk_main("relock", e);
            chk("relock_rst1", 32'(rst1), 32'(e < SS + 2));
        end

        // Lock low for 100 cycles after reset release
        ext_rst_n = 1'b0;
        lock_i = 1'b0;
        #1;
        chk("async_rst", 32'(rst), 32'hF);
        chk("async_done", 32'(rst_done), 32'h0);
        repeat (3) tick();
        ext_rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("nolock_rst", 32'(rst), 32'hF);
            chk("nolock_busy", 32'(busy), 32'h0);
        end
        lock_i = 1'b1;
        stop_e = $urandom_range(36, 50);
        for (int e = 1; e <= stop_e; e++) begin
            tick();
            chk_main("latelock", e);
        end

        // Asynchronous ext_rst_n assertion mid-release (rst == 4'b1100)
        chk("midrel_pre", 32'(rst), 32'hC);
        ext_rst_n = 1'b0;
        #1;
        chk("midrel_rst", 32'(rst), 32'hF);
        chk("midrel_done", 32'(rst_done), 32'h0);
        chk("midrel_busy", 32'(busy), 32'h0);
        chk("midrel_rst1", 32'(rst1), 32'h1);
        repeat (2) tick();

        // Lock loss at a random point of a fresh sequence
        ext_rst_n = 1'b1;
        p = $urandom_range(5, 70);
        for (int e = 1; e <= p; e++) begin
            tick();
            chk_main("randdrop", e);
        end
        lock_i = 1'b0;
        for (int e = p + 1; e <= p + SS; e++) begin
            tick();
            chk_main("randdrop_lag", e);
        end
        tick();
        chk("randdrop_rst", 32'(rst), 32'hF);
        chk("randdrop_done", 32'(rst_done), 32'h0);
        chk("randdrop_busy", 32'(busy), 32'h0);
        repeat ($urandom_range(1, 10)) tick();
        lock_i = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            tick();
            chk_main("final", e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
